// File: rtl/ins_cache.sv
// ins_cache: direct-mapped, read-only instruction cache that fills a whole line word by word on a miss.
// Optional macro ICACHE_FWD_EN forwards the fetched word straight from mem_data during a fill.
module ins_cache #(
  parameter int INDEX_BITS  = 6,
  parameter int OFFSET_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [31:0] addr,
  output logic        hit,
  output logic [31:0] ins,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data
);
  localparam int LINES    = 2**INDEX_BITS;
  localparam int WORDS    = 2**OFFSET_BITS;
  localparam int TAG_LSB  = INDEX_BITS + OFFSET_BITS + 2;
  localparam int TAG_BITS = 32 - TAG_LSB;
  localparam logic [OFFSET_BITS-1:0] LAST = '1;

  typedef enum logic {IDLE, FILL} state_t;

  state_t                 state_q, state_d;
  logic [OFFSET_BITS-1:0] cnt_q, cnt_d;
  logic                   mem_req_q, mem_req_d;
  logic [31:0]            mem_addr_q, mem_addr_d;
  logic [LINES-1:0]       valid_q, valid_d;
  logic [TAG_BITS-1:0]    tag_arr [LINES];
  logic [31:0]            data_arr [LINES][WORDS];

  logic [OFFSET_BITS-1:0] off;
  logic [INDEX_BITS-1:0]  idx, fill_idx;
  logic [TAG_BITS-1:0]    tag, fill_tag;
  logic                   arr_hit, data_we, tag_we;
  logic                   unused_addr_lsb;

  assign off             = addr[OFFSET_BITS+1:2];
  assign idx             = addr[TAG_LSB-1:OFFSET_BITS+2];
  assign tag             = addr[31:TAG_LSB];
  assign unused_addr_lsb = ^addr[1:0];

  // The line base of the fill lives in the upper bits of mem_addr_q, which never change mid-fill.
  assign fill_idx = mem_addr_q[TAG_LSB-1:OFFSET_BITS+2];
  assign fill_tag = mem_addr_q[31:TAG_LSB];
  assign arr_hit  = valid_q[idx] && (tag_arr[idx] == tag);

  always_comb begin
    hit = arr_hit;
    ins = arr_hit ? data_arr[idx][off] : 32'h0;
`ifdef ICACHE_FWD_EN
    if ((state_q == FILL) && mem_done && (mem_addr_q[31:2] == addr[31:2])) begin
      hit = 1'b1;
      ins = mem_data;
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    valid_d    = valid_q;
    data_we    = 1'b0;
    tag_we     = 1'b0;
    if (rdy) begin
      unique case (state_q)
        IDLE: begin
          if (!arr_hit) begin
            valid_d[idx] = 1'b0;
            cnt_d        = '0;
            mem_req_d    = 1'b1;
            mem_addr_d   = {addr[31:OFFSET_BITS+2], {(OFFSET_BITS+2){1'b0}}};
            state_d      = FILL;
          end
        end
        FILL: begin
          if (mem_done) begin
            data_we = 1'b1;
            if (cnt_q == LAST) begin
              tag_we            = 1'b1;
              valid_d[fill_idx] = 1'b1;
              mem_req_d         = 1'b0;
              state_d           = IDLE;
            end else begin
              cnt_d      = cnt_q + OFFSET_BITS'(1);
              mem_addr_d = mem_addr_q + 32'd4;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      valid_q    <= valid_d;
    end
  end

  // Tag and data storage are deliberately left unreset; valid alone qualifies them.
  always_ff @(posedge clk) begin
    if (data_we) data_arr[fill_idx][cnt_q] <= mem_data;
    if (tag_we)  tag_arr[fill_idx] <= fill_tag;
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_ins_cache.sv
// tb_ins_cache: directed scoreboard bench for ins_cache with a one-cycle-latency memory responder.
// Expected forwarding behaviour follows ICACHE_FWD_EN.
module tb_ins_cache;
  logic        clk = 1'b0;
  logic        rst, rdy;
  logic [31:0] addr;
  logic        hit;
  logic [31:0] ins;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_data;

  always #5 clk = ~clk;

  ins_cache dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .addr     (addr),
    .hit      (hit),
    .ins      (ins),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_done (mem_done),
    .mem_data (mem_data)
  );

`ifdef ICACHE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    int          id;
    logic        exp_hit;
    logic [31:0] exp_ins;
    logic        chk_req;
    logic        exp_req;
    logic        chk_addr;
    logic [31:0] exp_maddr;
  } probe_t;

  probe_t      probe_q[$];
  logic [31:0] req_q[$];
  logic        probe = 1'b0;
  logic [31:0] exp_a;
  int          tests = 0;
  int          fails = 0;
  int          done_cnt = 0;
  int          probe_id = 0;
  int          base;

  // Memory image: each word carries its own low address bits, so 0x48 reads 32'hC0DE_0048.
  function automatic logic [31:0] memword(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_line(input logic [31:0] b);
    for (int i = 0; i < 4; i++) req_q.push_back(b + 32'(4 * i));
  endtask

  task automatic apply_stimulus(input logic [31:0] a, input logic eh, input logic [31:0] ei,
                                input logic cr, input logic er, input logic ca, input logic [31:0] em);
    probe_t p;
    addr        = a;
    p.id        = probe_id;
    p.exp_hit   = eh;
    p.exp_ins   = ei;
    p.chk_req   = cr;
    p.exp_req   = er;
    p.chk_addr  = ca;
    p.exp_maddr = em;
    probe_id++;
    probe_q.push_back(p);
    probe = 1'b1;
    @(negedge clk);
    #1;
    probe = 1'b0;
    cyc();
  endtask

  task automatic check_output(input probe_t p);
    tests++;
    if (hit !== p.exp_hit || ins !== p.exp_ins) begin
      fails++;
      $display("[TB] FAIL probe%0d lookup addr=%h: hit=%b ins=%h, required hit=%b ins=%h",
               p.id, addr, hit, ins, p.exp_hit, p.exp_ins);
    end
    if (p.chk_req) begin
      tests++;
      if (mem_req !== p.exp_req) begin
        fails++;
        $display("[TB] FAIL probe%0d mem_req: got %b, required %b", p.id, mem_req, p.exp_req);
      end
    end
    if (p.chk_addr) begin
      tests++;
      if (mem_addr !== p.exp_maddr) begin
        fails++;
        $display("[TB] FAIL probe%0d mem_addr: got %h, required %h", p.id, mem_addr, p.exp_maddr);
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (mem_req === 1'b1 && n < budget) begin
      cyc();
      n++;
    end
    if (mem_req !== 1'b0) begin
      tests++;
      fails++;
      $display("[TB] FAIL wait_idle timeout: mem_req=%b, required 0", mem_req);
    end
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      cyc();
      n++;
    end
    if (done_cnt < target) begin
      tests++;
      fails++;
      $display("[TB] FAIL wait_done timeout: done_cnt=%0d, required %0d", done_cnt, target);
    end
  endtask

  // Memory controller model: one word per request, returned one idle cycle after the request appears.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    mem_done = 1'b0;
    mem_data = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      mem_done = 1'b0;
      if (rst !== 1'b1 || mem_req !== 1'b1) begin
        wait_cnt = 0;
      end else if (rdy) begin
        if (wait_cnt == 1) begin
          mem_done = 1'b1;
          mem_data = memword(mem_addr);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // Monitor: every returned word is matched against the next expected request address.
  always @(negedge clk) begin
    if (mem_done === 1'b1) begin
      done_cnt++;
      tests++;
      if (req_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_req: mem_addr=%h, required no request", mem_addr);
      end else begin
        exp_a = req_q.pop_front();
        if (mem_addr !== exp_a || mem_req !== 1'b1) begin
          fails++;
          $display("[TB] FAIL req_addr: mem_req=%b mem_addr=%h, required mem_req=1 mem_addr=%h",
                   mem_req, mem_addr, exp_a);
        end
      end
    end
    if (probe) begin
      if (probe_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL probe_underflow: got empty queue, required an entry");
      end else begin
        check_output(probe_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst  = 1'b0;
    rdy  = 1'b1;
    addr = 32'h0;
    repeat (2) cyc();

    // Reset state, then the first miss fills line 0x0.
    apply_stimulus(32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0);
    push_line(32'h0);
    rst = 1'b1;
    apply_stimulus(32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0);
    apply_stimulus(32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0);
    wait_idle(100);
    apply_stimulus(32'h0, 1'b1, 32'hC0DE_0000, 1'b1, 1'b0, 1'b0, 32'h0);
    apply_stimulus(32'h8, 1'b1, 32'hC0DE_0008, 1'b1, 1'b0, 1'b0, 32'h0);

    // Fill 0x40 while line 0x0 keeps hitting.
    push_line(32'h40);
    apply_stimulus(32'h40, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    apply_stimulus(32'h4, 1'b1, 32'hC0DE_0004, 1'b1, 1'b1, 1'b1, 32'h40);
    for (int n = 0; n < 100 && mem_req === 1'b1; n++)
      apply_stimulus(32'h4, 1'b1, 32'hC0DE_0004, 1'b0, 1'b0, 1'b0, 32'h0);
    wait_idle(10);
    apply_stimulus(32'h4C, 1'b1, 32'hC0DE_004C, 1'b1, 1'b0, 1'b0, 32'h0);

    // 0x400 evicts line 0; 0x0 then misses and refills.
    push_line(32'h400);
    apply_stimulus(32'h400, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    wait_idle(100);
    apply_stimulus(32'h400, 1'b1, 32'hC0DE_0400, 1'b1, 1'b0, 1'b0, 32'h0);
    push_line(32'h0);
    apply_stimulus(32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    apply_stimulus(32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0);
    wait_idle(100);
    apply_stimulus(32'h4, 1'b1, 32'hC0DE_0004, 1'b1, 1'b0, 1'b0, 32'h0);

    // Redirect after two words: the 0x50 fill completes before 0x100 starts.
    push_line(32'h50);
    push_line(32'h100);
    base = done_cnt;
    apply_stimulus(32'h50, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    wait_done(base + 2, 100);
    apply_stimulus(32'h100, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h58);
    for (int n = 0; n < 100 && mem_req === 1'b1; n++)
      apply_stimulus(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    apply_stimulus(32'h100, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    apply_stimulus(32'h100, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h100);
    wait_idle(100);
    apply_stimulus(32'h100, 1'b1, 32'hC0DE_0100, 1'b1, 1'b0, 1'b0, 32'h0);
    apply_stimulus(32'h5C, 1'b1, 32'hC0DE_005C, 1'b1, 1'b0, 1'b0, 32'h0);

    // rdy low for three cycles mid-fill freezes the request.
    push_line(32'h200);
    base = done_cnt;
    apply_stimulus(32'h200, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    wait_done(base + 1, 100);
    rdy = 1'b0;
    repeat (3) apply_stimulus(32'h200, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h204);
    rdy = 1'b1;
    wait_idle(100);
    apply_stimulus(32'h204, 1'b1, 32'hC0DE_0204, 1'b1, 1'b0, 1'b0, 32'h0);
    apply_stimulus(32'h20C, 1'b1, 32'hC0DE_020C, 1'b1, 1'b0, 1'b0, 32'h0);

    // Reset in the middle of a fill drops the request and invalidates every line.
    req_q.push_back(32'h300);
    base = done_cnt;
    apply_stimulus(32'h300, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    apply_stimulus(32'h0, 1'b1, 32'hC0DE_0000, 1'b1, 1'b1, 1'b1, 32'h300);
    wait_done(base + 1, 100);
    rst = 1'b0;
    apply_stimulus(32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0);

    // Critical word 0x48 arrives third; it hits that cycle only with forwarding.
    push_line(32'h40);
    base = done_cnt;
    addr = 32'h48;
    rst  = 1'b1;
    cyc();
    wait_done(base + 2, 100);
    apply_stimulus(32'h48, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h48);
    apply_stimulus(32'h48, FWD, FWD ? 32'hC0DE_0048 : 32'h0, 1'b1, 1'b1, 1'b1, 32'h48);
    wait_idle(100);
    apply_stimulus(32'h48, 1'b1, 32'hC0DE_0048, 1'b1, 1'b0, 1'b0, 32'h0);

    // Top-of-memory line fills without crossing its boundary.
    push_line(32'hFFFF_FFF0);
    apply_stimulus(32'hFFFF_FFF8, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    apply_stimulus(32'hFFFF_FFF8, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFF0);
    wait_idle(100);
    apply_stimulus(32'hFFFF_FFF0, 1'b1, 32'hC0DE_FFF0, 1'b1, 1'b0, 1'b0, 32'h0);
    apply_stimulus(32'hFFFF_FFFC, 1'b1, 32'hC0DE_FFFC, 1'b1, 1'b0, 1'b0, 32'h0);

    repeat (2) cyc();
    tests++;
    if (req_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL req_leftover: %0d requests outstanding, required 0", req_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
